// File: rtl/rect_fill_ctrl_pkg.sv
// rect_fill_ctrl_pkg: shared FSM state type and default geometry for the rectangle fill sequencer.
package rect_fill_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LATCH, FILL, DONE} state_t;
    localparam int H_SIZE_DEF = 640;
    localparam int V_LINE_DEF = 480;
    localparam int COLOR_DEPTH_DEF = 8;
endpackage

// File: rtl/rect_corner_norm.sv
// rect_corner_norm: orders two corner coordinates on one axis and clips (RECT_FILL_CLIP_EN) or range-checks them.
module rect_corner_norm #(
    parameter int W = 10,
    parameter int LIM = 639
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         ok
);
    localparam logic [W-1:0] MAX = W'(LIM);
    logic [W-1:0] ca, cb;
`ifdef RECT_FILL_CLIP_EN
    assign ca = a > MAX ? MAX : a;
    assign cb = b > MAX ? MAX : b;
    assign ok = 1'b1;
`else
    assign ca = a;
    assign cb = b;
    assign ok = a <= MAX && b <= MAX;
`endif
    assign lo = ca < cb ? ca : cb;
    assign hi = ca < cb ? cb : ca;
endmodule

// File: rtl/rect_fill_ctrl.sv
// rect_fill_ctrl: accepts one rectangle-fill command and streams raster-order pixel writes.
// Defining RECT_FILL_CLIP_EN clamps out-of-range corners instead of rejecting the command.
module rect_fill_ctrl
    import rect_fill_ctrl_pkg::*;
#(
    parameter  int h_size = H_SIZE_DEF,
    parameter  int v_line = V_LINE_DEF,
    parameter  int color_depth = COLOR_DEPTH_DEF,
    localparam int HW = $clog2(h_size),
    localparam int VW = $clog2(v_line)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [HW-1:0]          cmd_x0,
    input  logic [VW-1:0]          cmd_y0,
    input  logic [HW-1:0]          cmd_x1,
    input  logic [VW-1:0]          cmd_y1,
    input  logic [color_depth-1:0] cmd_color,
    input  logic                   wr_stall,
    output logic                   wr_en,
    output logic [HW-1:0]          wr_h,
    output logic [VW-1:0]          wr_v,
    output logic [color_depth-1:0] wr_color,
    output logic                   busy,
    output logic                   done,
    output logic                   cmd_err
);
    state_t state, next;
    logic [HW-1:0] x0, x1, xmin, xmax, cx, lx;
    logic [VW-1:0] y0, y1, ymin, ymax, cy, ly;
    logic [color_depth-1:0] col, lc;
    logic okx, oky, err, last;

    rect_corner_norm #(.W(HW), .LIM(h_size - 1)) u_norm_x (.a(x0), .b(x1), .lo(xmin), .hi(xmax), .ok(okx));
    rect_corner_norm #(.W(VW), .LIM(v_line - 1)) u_norm_y (.a(y0), .b(y1), .lo(ymin), .hi(ymax), .ok(oky));

    assign last      = cx == xmax && cy == ymax;
    assign wr_en     = state == FILL && !wr_stall;
    // Outputs show the pixel being written, otherwise the last one written.
    assign wr_h      = wr_en ? cx : lx;
    assign wr_v      = wr_en ? cy : ly;
    assign wr_color  = wr_en ? col : lc;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign cmd_err   = err;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = cmd_valid ? LATCH : IDLE;
            LATCH:   next = okx && oky ? FILL : IDLE;
            FILL:    next = wr_en && last ? DONE : FILL;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            err   <= 1'b0;
            x0    <= '0;
            x1    <= '0;
            y0    <= '0;
            y1    <= '0;
            col   <= '0;
            cx    <= '0;
            cy    <= '0;
            lx    <= '0;
            ly    <= '0;
            lc    <= '0;
        end else begin
            state <= next;
            err   <= state == LATCH && !(okx && oky);
            if (state == IDLE && cmd_valid) begin
                x0  <= cmd_x0;
                x1  <= cmd_x1;
                y0  <= cmd_y0;
                y1  <= cmd_y1;
                col <= cmd_color;
            end
            if (state == LATCH) begin
                cx <= xmin;
                cy <= ymin;
            end
            // The counters stop on the final pixel so they never pass xmax/ymax.
            if (wr_en) begin
                lx <= cx;
                ly <= cy;
                lc <= col;
                if (!last) begin
                    cx <= cx == xmax ? xmin : cx + 1'b1;
                    cy <= cx == xmax ? cy + 1'b1 : cy;
                end
            end
        end
    end
endmodule
